// File: rtl/pipe_pkg.sv
// Shared definitions for the issue controller and its scoreboard.
package pipe_pkg;

  localparam int unsigned REG_W    = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned FUNC_MAX = 11;

  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_MUL   = 4'd2,
    FN_PASSA = 4'd3,
    FN_PASSB = 4'd4,
    FN_AND   = 4'd5,
    FN_DIV   = 4'd6,
    FN_XOR   = 4'd7,
    FN_NEGA  = 4'd8,
    FN_NEGB  = 4'd9,
    FN_SHR   = 4'd10,
    FN_SHL   = 4'd11
  } func_e;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// Register scoreboard: busy bits plus a retire token pipe that clears them
// WB_LAT cycles after issue.
module pipe_scoreboard #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned WB_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [3:0]      set_rd,
  input  logic            tok_load,
  input  logic [3:0]      tok_rd,
  output logic [NREG-1:0] busy_vec
);
  import pipe_pkg::*;

  logic [WB_LAT-1:0] tok_v;
  logic [REG_W-1:0]  tok_r [WB_LAT];
  logic [NREG-1:0]   busy_d;

  // Next busy vector: retiring token clears, new issue sets (never the same reg).
  always_comb begin
    busy_d = busy_vec;
    if (tok_v[WB_LAT-1]) busy_d[tok_r[WB_LAT-1]] = 1'b0;
    if (set_en)          busy_d[set_rd]           = 1'b1;
  end

  // Busy vector and token shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      tok_v    <= '0;
      for (int unsigned i = 0; i < WB_LAT; i++) tok_r[i] <= '0;
    end else begin
      busy_vec <= busy_d;
      tok_v[0] <= tok_load;
      tok_r[0] <= tok_rd;
      for (int unsigned i = 1; i < WB_LAT; i++) begin
        tok_v[i] <= tok_v[i-1];
        tok_r[i] <= tok_r[i-1];
      end
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: round-robin arbitration between two requesters with a
// RAW/WAW scoreboard, issuing one registered instruction per cycle.
module pipe_issue_ctrl #(
  parameter int unsigned NREG     = 16,
  parameter int unsigned WB_LAT   = 3,
  parameter int unsigned FUNC_MAX = pipe_pkg::FUNC_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [3:0]      req0_rs1,
  input  logic [3:0]      req0_rs2,
  input  logic [3:0]      req0_rd,
  input  logic [3:0]      req0_func,
  input  logic [7:0]      req0_addr,
  input  logic [3:0]      req1_rs1,
  input  logic [3:0]      req1_rs2,
  input  logic [3:0]      req1_rd,
  input  logic [3:0]      req1_func,
  input  logic [7:0]      req1_addr,
  output logic            iss_valid,
  output logic [3:0]      iss_rs1,
  output logic [3:0]      iss_rs2,
  output logic [3:0]      iss_rd,
  output logic [3:0]      iss_func,
  output logic [7:0]      iss_addr,
  output logic            iss_src,
  output logic            err_func,
  output logic [NREG-1:0] busy_vec,
  output logic [15:0]     issue_cnt
);
  import pipe_pkg::*;

  instr_t     req [2];
  logic [1:0] legal;
  logic [1:0] eligible;
  logic       ptr;
  logic       hs;
  logic       gsel;
  instr_t     sel;

  assign req[0] = '{rs1: req0_rs1, rs2: req0_rs2, rd: req0_rd, func: req0_func, addr: req0_addr};
  assign req[1] = '{rs1: req1_rs1, rs2: req1_rs2, rd: req1_rd, func: req1_func, addr: req1_addr};

  // Eligibility: valid, not held, not in reset, and operands free unless the func is illegal.
  always_comb begin
    legal    = '0;
    eligible = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      legal[i]    = (32'(req[i].func) <= FUNC_MAX);
      eligible[i] = rst_n && req_valid[i] && !hold &&
                    (!legal[i] || !(busy_vec[req[i].rs1] || busy_vec[req[i].rs2] ||
                                    busy_vec[req[i].rd]));
    end
  end

  // Grant: pointer breaks ties, otherwise the single eligible requester wins.
  always_comb begin
    req_ready = '0;
    if (&eligible) req_ready = ptr ? 2'b10 : 2'b01;
    else           req_ready = eligible;
    hs   = |(req_valid & req_ready);
    gsel = req_ready[1];
    sel  = req[gsel];
  end

  // Issue registers, error pulse, round-robin pointer and issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      iss_src   <= 1'b0;
      err_func  <= 1'b0;
      ptr       <= 1'b0;
      issue_cnt <= '0;
    end else begin
      iss_valid <= hs && legal[gsel];
      err_func  <= hs && !legal[gsel];
      if (hs) ptr <= !gsel;
      if (hs && legal[gsel]) begin
        iss_rs1   <= sel.rs1;
        iss_rs2   <= sel.rs2;
        iss_rd    <= sel.rd;
        iss_func  <= sel.func;
        iss_addr  <= sel.addr;
        iss_src   <= gsel;
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end

  // Tokens enter the retire pipe when the issue is presented to stage 1.
  pipe_scoreboard #(
    .NREG   (NREG),
    .WB_LAT (WB_LAT)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (hs && legal[gsel]),
    .set_rd   (sel.rd),
    .tok_load (iss_valid),
    .tok_rd   (iss_rd),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_issue_ctrl;
  import pipe_pkg::*;

  localparam int WB_LAT = 3;
  localparam int FMAX   = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  instr_t      a_i = '0;
  instr_t      b_i = '0;
  logic        iss_valid, iss_src, err_func;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
  logic [15:0] busy_vec, issue_cnt;

  pipe_issue_ctrl #(.NREG(16), .WB_LAT(WB_LAT), .FUNC_MAX(FMAX)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
    .req0_rs1(a_i.rs1), .req0_rs2(a_i.rs2), .req0_rd(a_i.rd), .req0_func(a_i.func), .req0_addr(a_i.addr),
    .req1_rs1(b_i.rs1), .req1_rs2(b_i.rs2), .req1_rd(b_i.rd), .req1_func(b_i.func), .req1_addr(b_i.addr),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_func(iss_func), .iss_addr(iss_addr), .iss_src(iss_src), .err_func(err_func),
    .busy_vec(busy_vec), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: per register the last cycle it is still busy, a
  // round-robin preference, and the count of legal issues.
  int          busy_until [16];
  int          ptr_m = 0;
  logic [15:0] cnt_m = '0;

  typedef struct {
    int          k;
    logic        err;
    instr_t      ins;
    logic        src;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic reg_busy(input logic [3:0] r);
    return cyc <= busy_until[r];
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = reg_busy(4'(r));
    return b;
  endfunction

  function automatic logic can_go(input instr_t x);
    return (x.func > FMAX) || !(reg_busy(x.rs1) || reg_busy(x.rs2) || reg_busy(x.rd));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) busy_until[r] = -1;
    ptr_m = 0;
    cnt_m = '0;
    q.delete();
  endtask

  // Predict the grant for this cycle, compare, and queue the expected issue.
  task automatic model_eval();
    logic [1:0] el, er;
    instr_t     x;
    logic       g;
    el[0] = rst_n && req_valid[0] && !hold && can_go(a_i);
    el[1] = rst_n && req_valid[1] && !hold && can_go(b_i);
    if (el == 2'b11) er = (ptr_m == 1) ? 2'b10 : 2'b01;
    else             er = el;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy_vec", 32'(busy_vec), 32'(model_busy()));
    if (er != 2'b00) begin
      g     = er[1];
      x     = g ? b_i : a_i;
      ptr_m = g ? 0 : 1;
      if (x.func > FMAX) begin
        q.push_back('{k: cyc, err: 1'b1, ins: x, src: g, cnt: cnt_m});
      end else begin
        cnt_m = cnt_m + 16'd1;
        busy_until[x.rd] = cyc + WB_LAT + 1;
        q.push_back('{k: cyc, err: 1'b0, ins: x, src: g, cnt: cnt_m});
      end
    end
  endtask

  task automatic step(input logic [1:0] v, input logic h, input instr_t a, input instr_t b);
    @(posedge clk);
    cyc++;
    #2;
    req_valid = v;
    hold      = h;
    a_i       = a;
    b_i       = b;
    #1;
    model_eval();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, '0, '0);
  endtask

  task automatic release_rst();
    req_valid = 2'b00;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int f, input int ad);
    instr_t x;
    x.rs1 = 4'(rs1); x.rs2 = 4'(rs2); x.rd = 4'(rd); x.func = 4'(f); x.addr = 8'(ad);
    return x;
  endfunction

  function automatic instr_t rnd_instr();
    return mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 13), $urandom_range(0, 255));
  endfunction

  // Monitor: pops the scoreboard whenever an issue or error is due.
  exp_t e;
  logic hit;
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].k < cyc - 1) begin
        chk("iss_missing", 32'(q[0].k), 32'(cyc - 1));
        void'(q.pop_front());
      end
      hit = (q.size() > 0) && (q[0].k == cyc - 1);
      if (hit) begin
        e = q.pop_front();
        chk("iss_valid", 32'(iss_valid), 32'(!e.err));
        chk("err_func", 32'(err_func), 32'(e.err));
        chk("issue_cnt", 32'(issue_cnt), 32'(e.cnt));
        if (!e.err) begin
          chk("iss_rs1", 32'(iss_rs1), 32'(e.ins.rs1));
          chk("iss_rs2", 32'(iss_rs2), 32'(e.ins.rs2));
          chk("iss_rd", 32'(iss_rd), 32'(e.ins.rd));
          chk("iss_func", 32'(iss_func), 32'(e.ins.func));
          chk("iss_addr", 32'(iss_addr), 32'(e.ins.addr));
          chk("iss_src", 32'(iss_src), 32'(e.src));
        end
      end else begin
        chk("iss_valid_idle", 32'(iss_valid), 32'd0);
        chk("err_func_idle", 32'(err_func), 32'd0);
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int k0;
  int hs_cyc;

  initial begin
    model_reset();
    // Reset state, with requests presented while reset is low.
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 32'd0);
    chk("rst_iss_src", 32'(iss_src), 32'd0);
    chk("rst_err_func", 32'(err_func), 32'd0);
    chk("rst_busy_vec", 32'(busy_vec), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    step(2'b11, 1'b0, mk(1, 2, 3, 0, 0), mk(4, 5, 6, 0, 0));
    release_rst();

    // Single request: rd=3 busy for four cycles.
    step(2'b01, 1'b0, mk(1, 2, 3, 0, 8'h5a), '0);
    chk("single_ready", 32'(req_ready), 32'd1);
    idle(6);

    // RAW stall: dependent request waits WB_LAT+2 cycles.
    step(2'b01, 1'b0, mk(1, 2, 3, 1, 8'h11), '0);
    k0 = cyc;
    hs_cyc = -1;
    for (int j = 0; j < 20 && hs_cyc < 0; j++) begin
      step(2'b10, 1'b0, '0, mk(3, 6, 7, 2, 8'h22));
      if (req_ready[1]) hs_cyc = cyc;
    end
    chk("raw_delay", 32'(hs_cyc - k0), 32'd5);
    idle(6);

    // Round-robin with both requesters continuously eligible.
    for (int j = 0; j < 16; j++)
      step(2'b11, 1'b0, mk(j % 8, j % 8, j % 8, j % 12, j), mk(8 + j % 8, 8 + j % 8, 8 + j % 8, 3, 100 + j));
    idle(6);

    // Illegal func is consumed and flagged, nothing issues.
    step(2'b01, 1'b0, mk(1, 2, 3, 12, 0), '0);
    step(2'b00, 1'b0, '0, '0);
    chk("illegal_err", 32'(err_func), 32'd1);
    chk("illegal_iss", 32'(iss_valid), 32'd0);
    idle(2);

    // hold blocks grants while an earlier token still retires on time.
    step(2'b10, 1'b0, '0, mk(0, 1, 5, 4, 9));
    for (int j = 0; j < 6; j++) step(2'b11, 1'b1, mk(1, 2, 3, 0, 1), mk(6, 7, 8, 0, 2));
    chk("hold_busy_cleared", 32'(busy_vec), 32'd0);
    idle(2);

    // Asynchronous reset with two registers in flight.
    step(2'b01, 1'b0, mk(1, 2, 3, 0, 1), '0);
    step(2'b10, 1'b0, '0, mk(6, 7, 4, 0, 2));
    step(2'b00, 1'b0, '0, '0);
    chk("pre_reset_busy", 32'(busy_vec), 32'h0018);
    #1;
    rst_n = 1'b0;
    model_reset();
    #0.5;
    chk("mid_rst_busy", 32'(busy_vec), 32'd0);
    chk("mid_rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("mid_rst_issue_cnt", 32'(issue_cnt), 32'd0);
    step(2'b11, 1'b0, mk(1, 2, 3, 0, 0), mk(4, 5, 6, 0, 0));
    release_rst();

    // Counter wrap: 65536 back-to-back legal issues return the count to 0.
    for (int j = 0; j < 65536; j++) step(2'b01, 1'b0, mk(j % 8, j % 8, j % 8, 0, j), '0);
    idle(2);
    chk("cnt_wrap", 32'(issue_cnt), 32'd0);
    idle(4);

    // Randomized traffic.
    for (int j = 0; j < 1500; j++)
      step(2'(($urandom_range(0, 9) < 7 ? 1 : 0) | (($urandom_range(0, 9) < 7 ? 1 : 0) << 1)),
           ($urandom_range(0, 7) == 0), rnd_instr(), rnd_instr());
    idle(8);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
